// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch/sequence stage holding PC, IR and {carry,zero} flags; optional SINGLE_STEP_EN adds step_i.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC) with zero-wait memory, plus one per memory wait cycle.
// Backpressure: FETCH holds req/addr until imem_ack_i; with SINGLE_STEP_EN, DECODE holds until step_i.
module fetch_seq #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [3+ADDR_W-1:0] imem_data_i,
    output logic [2:0]          op_o,
    output logic [ADDR_W-1:0]   operand_o,
    output logic [1:0]          flags_o,
    input  logic                jmp_i,
    input  logic                wf_i,
    input  logic [1:0]          flags_d_i,
`ifdef SINGLE_STEP_EN
    input  logic                step_i,
`endif
    output logic                exec_o,
    output logic [ADDR_W-1:0]   pc_o
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        DECODE   = 2'd2,
        EXEC     = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [3+ADDR_W-1:0] ir;
    logic [1:0]          flags;

    // State register; reset parks in RST_WAIT so the first fetch starts one cycle after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: FETCH waits for ack, DECODE settles (or waits for a step), EXEC always returns to FETCH.
    always_comb begin
        state_nxt = state;
        case (state)
            RST_WAIT: state_nxt = FETCH;
            FETCH:    state_nxt = imem_ack_i ? DECODE : FETCH;
`ifdef SINGLE_STEP_EN
            DECODE:   state_nxt = step_i ? EXEC : DECODE;
`else
            DECODE:   state_nxt = EXEC;
`endif
            EXEC:     state_nxt = FETCH;
            default:  state_nxt = RST_WAIT;
        endcase
    end

    // Handshake and execute strobes come from the registered state only, so inputs never reach them combinationally.
    always_comb begin
        imem_req_o = 1'b0;
        exec_o     = 1'b0;
        case (state)
            FETCH:   imem_req_o = 1'b1;
            EXEC:    exec_o     = 1'b1;
            default: begin
                imem_req_o = 1'b0;
                exec_o     = 1'b0;
            end
        endcase
    end

    // Architectural registers: IR loads only on an ack seen in FETCH; PC and flags commit only at the EXEC closing edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc    <= RESET_PC;
            ir    <= '0;
            flags <= 2'b00;
        end else begin
            if (state == FETCH && imem_ack_i) begin
                ir <= imem_data_i;
            end
            if (state == EXEC) begin
                // Jump target and pc+1 both wrap naturally at 2^ADDR_W.
                pc <= jmp_i ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
                if (wf_i) begin
                    flags <= flags_d_i;
                end
            end
        end
    end

    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign op_o        = ir[3+ADDR_W-1 -: 3];
    assign operand_o   = ir[ADDR_W-1:0];
    assign flags_o     = flags;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction fetch and sequencing stage directly upstream of the control unit in the accumulator CPU. It holds the PC, IR and flags register. It fetches 8-bit instruction words over a req/ack memory handshake and presents opcode and flags to the control unit. It then applies the control unit's jmp/wf decisions in a one-cycle execute slot.

Parameters:
ADDR_W, 5, PC / operand width; instruction word = 3-bit opcode + ADDR_W operand.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
imem_req_o  out  1  fetch request; high only in FETCH.
imem_addr_o  out  ADDR_W  fetch address (= PC).
imem_ack_i  in  1  memory ack; data valid in the same cycle.
imem_data_i  in  3+ADDR_W  instruction word {op[2:0], operand}.
op_o  out  3  IR opcode field, feeds control unit op_i.
operand_o  out  ADDR_W  IR operand field (jump target / memory address / immediate).
flags_o  out  2  {carry, zero} register, feeds control unit flags_i.
jmp_i  in  1  control unit PC-load request.
wf_i  in  1  control unit flags-write enable.
flags_d_i  in  2  new {carry, zero} from ALU.
exec_o  out  1  one-cycle execute strobe; wr/wm/wf may only commit while high.
pc_o  out  ADDR_W  current PC, for debug.

Behaviour:
- Reset (async, rst_i=1): state=RST_WAIT; pc=RESET_PC; IR=0 (op_o=0, operand_o=0); flags_o=2'b00; imem_req_o=0; exec_o=0. Outputs change immediately on reset assertion, without waiting for a clock edge.
- imem_req_o and exec_o are decoded from the registered state only; no input-to-output combinational path on them.
- FSM states:
  - RST_WAIT: always goes to FETCH on the next edge.
  - FETCH: req=1, addr=pc. On an edge with imem_ack_i=1, IR<=imem_data_i and the FSM goes to DECODE. With ack=0 it stays in FETCH, holding req and addr stable. Ack in the first FETCH cycle is legal (zero-wait memory).
  - DECODE: op_o and operand_o are stable; one cycle for the control unit and ALU to settle. Goes to EXEC.
  - EXEC: exec_o=1 for exactly one cycle. At the closing edge:
    - pc <= operand if jmp_i=1, else pc+1 modulo 2^ADDR_W (31 -> 0 wraps).
    - flags <= flags_d_i if wf_i=1, else unchanged.
    - Goes to FETCH.
- Fixed 3-cycle instruction latency with zero-wait memory (FETCH, DECODE, EXEC); each memory wait cycle adds one.
- jmp_i, wf_i and flags_d_i are ignored outside EXEC.
- imem_ack_i outside FETCH is ignored, with no IR change.
- Reset mid-FETCH drops req immediately. Any pending ack is discarded.
- Reset mid-EXEC: no PC or flags update.
- Simultaneous jmp_i and wf_i in EXEC: both take effect at the same edge. The conditional-jump decision uses the pre-update flags_o.

Optional Feature:
SINGLE_STEP_EN.
- Defined: adds input port step_i (1 bit). DECODE holds until step_i=1 at an edge, then goes to EXEC; the step is consumed. A step_i level held high advances one instruction per pass through DECODE, with no extra edge detection. op_o stays stable while holding.
- Undefined: no step_i port; DECODE always lasts exactly one cycle.

Test Plan:
- Reset release, zero-wait memory, word {100,00111} (JMP 7) at addr 0, jmp_i=1 in EXEC -> req at cycle 1 with addr 0; exec_o high exactly at cycle 3; pc_o=7 afterwards; next req uses addr 7.
- Memory wait of 3 cycles on a fetch at pc=2 -> req held and addr stable at 2 for 4 cycles; IR loads only on the ack cycle; exec_o asserts 2 cycles after ack.
- PC=31, non-jump instruction (jmp_i=0) -> pc_o=0 after EXEC.
- EXEC with wf_i=1, flags_d_i=2'b01 -> flags_o=01 after the edge. Next EXEC with wf_i=0, flags_d_i=2'b10 -> flags_o stays 01.
- rst_i asserted mid-FETCH, then mid-EXEC with jmp_i=1 -> req drops to 0 immediately; pc_o=RESET_PC; flags_o=00; no PC jump.
- SINGLE_STEP_EN: step_i=0 for 5 cycles in DECODE -> exec_o stays 0 and op_o stays stable. A one-cycle step_i pulse -> exactly one exec_o pulse.
